// File: rtl/ifu_fetch_ctrl_if.sv
// IFU link bundle: decoder handshake, writeback next-PC, memory req/resp port
// and status. The master modport is the fetch unit; slave is its environment.
interface ifu_fetch_ctrl_if;
    logic        IFU_valid;
    logic        IDU_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pc_update;
    logic [31:0] dnpc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_err;
    logic        fetch_err;
    logic [31:0] inst_cnt;

    modport master (
        output IFU_valid, inst, pc, mem_req_valid, mem_addr, fetch_err, inst_cnt,
        input  IDU_ready, pc_update, dnpc, mem_req_ready, mem_resp_valid,
               mem_resp_data, mem_resp_err
    );

    modport slave (
        input  IFU_valid, inst, pc, mem_req_valid, mem_addr, fetch_err, inst_cnt,
        output IDU_ready, pc_update, dnpc, mem_req_ready, mem_resp_valid,
               mem_resp_data, mem_resp_err
    );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller. One instruction in flight: request the word at
// pc, hold it toward the decoder until accepted, then wait for writeback to
// supply the next pc. Bus errors, wait timeouts and misaligned targets park
// the unit in a terminal error state until reset.
module ifu_fetch_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h8000_0000,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    ifu_fetch_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_WAIT = 3'd1,
        S_HOLD = 3'd2,
        S_EXEC = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Counter only as wide as the timeout needs; at least one bit.
    localparam int unsigned   CW         = (WAIT_TIMEOUT > 32'd1) ? $clog2(WAIT_TIMEOUT + 32'd1) : 1;
    localparam logic [CW-1:0] TIMEOUT_V  = CW'(WAIT_TIMEOUT);
    localparam bit            TIMEOUT_EN = (WAIT_TIMEOUT != 32'd0);

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] wait_cnt_r;
    logic [CW-1:0] wait_cnt_s;
    logic [31:0]   pc_r;
    logic [31:0]   pc_s;
    logic [31:0]   inst_r;
    logic [31:0]   inst_s;
    logic [31:0]   inst_cnt_r;
    logic [31:0]   inst_cnt_s;
    logic          ifu_valid_r;
    logic          mem_req_valid_r;
    logic          fetch_err_r;

    logic          req_fire_s;
    logic          hs_fire_s;
    logic          misaligned_s;

    assign req_fire_s   = mem_req_valid_r & bus.mem_req_ready;
    assign hs_fire_s    = ifu_valid_r & bus.IDU_ready;
    assign misaligned_s = (bus.dnpc[1:0] != 2'b00);

    // Next-state and next-datapath values for the fetch sequence.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        pc_s       = pc_r;
        inst_s     = inst_r;
        inst_cnt_s = inst_cnt_r;
        case (state_r)
            S_REQ: begin
                // Cleared here so every S_WAIT visit starts counting from zero.
                wait_cnt_s = '0;
                if (req_fire_s) begin
                    state_s = S_WAIT;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_WAIT: begin
                // Value after this cycle = number of S_WAIT cycles spent so far.
                wait_cnt_s = wait_cnt_r + CW'(1'b1);
                if (bus.mem_resp_valid) begin
                    if (bus.mem_resp_err) begin
                        state_s = S_ERR;
                    end else begin
                        inst_s  = bus.mem_resp_data;
                        state_s = S_HOLD;
                    end
                end else if (TIMEOUT_EN && (wait_cnt_s == TIMEOUT_V)) begin
                    state_s = S_ERR;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_HOLD: begin
                if (hs_fire_s) begin
                    inst_cnt_s = inst_cnt_r + 32'd1;
                    state_s    = S_EXEC;
                end else begin
                    state_s = S_HOLD;
                end
            end
            S_EXEC: begin
                if (bus.pc_update) begin
                    pc_s = bus.dnpc;
                    if (misaligned_s) begin
                        state_s = S_ERR;
                    end else begin
                        state_s = S_REQ;
                    end
                end else begin
                    state_s = S_EXEC;
                end
            end
            S_ERR: begin
                state_s = S_ERR;
            end
            default: begin
                // Unreachable encodings are treated as a fault.
                state_s = S_ERR;
            end
        endcase
    end

    // State, datapath and registered outputs; outputs follow the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= S_REQ;
            wait_cnt_r      <= '0;
            pc_r            <= RESET_PC;
            inst_r          <= 32'd0;
            inst_cnt_r      <= 32'd0;
            ifu_valid_r     <= 1'b0;
            mem_req_valid_r <= 1'b0;
            fetch_err_r     <= 1'b0;
        end else begin
            state_r         <= state_s;
            wait_cnt_r      <= wait_cnt_s;
            pc_r            <= pc_s;
            inst_r          <= inst_s;
            inst_cnt_r      <= inst_cnt_s;
            ifu_valid_r     <= (state_s == S_HOLD);
            mem_req_valid_r <= (state_s == S_REQ);
            fetch_err_r     <= fetch_err_r | (state_s == S_ERR);
        end
    end

    assign bus.IFU_valid     = ifu_valid_r;
    assign bus.inst          = inst_r;
    assign bus.pc            = pc_r;
    assign bus.mem_req_valid = mem_req_valid_r;
    assign bus.mem_addr      = pc_r;
    assign bus.fetch_err     = fetch_err_r;
    assign bus.inst_cnt      = inst_cnt_r;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: plays memory, decoder and writeback, and tracks
// the expected pc / instruction count at instruction granularity.
module tb_ifu_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          TO       = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifu_fetch_ctrl_if bus_if ();

    ifu_fetch_ctrl #(.RESET_PC(RESET_PC), .WAIT_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus_if.IDU_ready      = 1'b0;
        bus_if.pc_update      = 1'b0;
        bus_if.dnpc           = 32'd0;
        bus_if.mem_req_ready  = 1'b0;
        bus_if.mem_resp_valid = 1'b0;
        bus_if.mem_resp_data  = 32'd0;
        bus_if.mem_resp_err   = 1'b0;
    endtask

    task automatic check_reset_vals(input string p);
        chk1({p, ".IFU_valid"}, bus_if.IFU_valid, 1'b0);
        chk ({p, ".inst"}, bus_if.inst, 32'd0);
        chk ({p, ".pc"}, bus_if.pc, RESET_PC);
        chk ({p, ".mem_addr"}, bus_if.mem_addr, RESET_PC);
        chk1({p, ".mem_req_valid"}, bus_if.mem_req_valid, 1'b0);
        chk1({p, ".fetch_err"}, bus_if.fetch_err, 1'b0);
        chk ({p, ".inst_cnt"}, bus_if.inst_cnt, 32'd0);
    endtask

    // Wait (bounded) for a request, stall it, then accept it. Ignored
    // pc_update pulses and an early response are thrown in while in S_REQ.
    task automatic issue_req(input int req_delay);
        for (int i = 0; i < 20 && bus_if.mem_req_valid !== 1'b1; i++) step();
        chk1("req_seen", bus_if.mem_req_valid, 1'b1);
        chk("req_addr", bus_if.mem_addr, m_pc);
        for (int i = 0; i < req_delay; i++) begin
            bus_if.pc_update      = 1'b1;
            bus_if.dnpc           = $urandom();
            bus_if.mem_resp_valid = 1'b1;
            bus_if.mem_resp_data  = $urandom();
            step();
            chk1("req_stall_valid", bus_if.mem_req_valid, 1'b1);
            chk("req_stall_pc", bus_if.pc, m_pc);
        end
        bus_if.pc_update      = 1'b0;
        bus_if.mem_req_ready  = 1'b1;
        bus_if.mem_resp_valid = 1'b1;
        bus_if.mem_resp_data  = 32'hDEAD_BEEF;
        step();
        bus_if.mem_req_ready  = 1'b0;
        bus_if.mem_resp_valid = 1'b0;
        chk1("req_drop", bus_if.mem_req_valid, 1'b0);
        chk1("same_cycle_resp_ignored", bus_if.IFU_valid, 1'b0);
    endtask

    // Response arrives in S_WAIT cycle lat (1 = first wait cycle).
    task automatic respond(input int lat, input logic [31:0] data, input logic err);
        for (int k = 1; k < lat; k++) begin
            bus_if.pc_update = 1'($urandom_range(0, 1));
            bus_if.dnpc      = $urandom();
            step();
            chk1("wait_valid", bus_if.IFU_valid, 1'b0);
            chk1("wait_err", bus_if.fetch_err, 1'b0);
            chk("wait_pc", bus_if.pc, m_pc);
        end
        bus_if.pc_update      = 1'b0;
        bus_if.mem_resp_valid = 1'b1;
        bus_if.mem_resp_data  = data;
        bus_if.mem_resp_err   = err;
        step();
        bus_if.mem_resp_valid = 1'b0;
        bus_if.mem_resp_err   = 1'b0;
        if (err) begin
            chk1("resp_err_flag", bus_if.fetch_err, 1'b1);
            chk1("resp_err_valid", bus_if.IFU_valid, 1'b0);
        end else begin
            chk1("resp_valid", bus_if.IFU_valid, 1'b1);
            chk("resp_inst", bus_if.inst, data);
            chk("resp_pc", bus_if.pc, m_pc);
        end
    endtask

    task automatic hold_and_take(input int hold, input logic [31:0] data);
        for (int i = 0; i < hold; i++) begin
            bus_if.IDU_ready = 1'b0;
            bus_if.pc_update = 1'($urandom_range(0, 1));
            bus_if.dnpc      = $urandom();
            step();
            chk1("hold_valid", bus_if.IFU_valid, 1'b1);
            chk("hold_inst", bus_if.inst, data);
            chk("hold_pc", bus_if.pc, m_pc);
        end
        bus_if.pc_update = 1'b0;
        bus_if.IDU_ready = 1'b1;
        step();
        bus_if.IDU_ready = 1'b0;
        m_cnt = m_cnt + 32'd1;
        chk1("take_valid", bus_if.IFU_valid, 1'b0);
        chk("take_cnt", bus_if.inst_cnt, m_cnt);
    endtask

    task automatic exec_update(input int idle, input logic [31:0] npc);
        for (int i = 0; i < idle; i++) begin
            bus_if.IDU_ready = 1'($urandom_range(0, 1));
            step();
            chk("exec_cnt", bus_if.inst_cnt, m_cnt);
            chk1("exec_req", bus_if.mem_req_valid, 1'b0);
            chk1("exec_valid", bus_if.IFU_valid, 1'b0);
        end
        bus_if.IDU_ready = 1'b0;
        bus_if.pc_update = 1'b1;
        bus_if.dnpc      = npc;
        step();
        bus_if.pc_update = 1'b0;
        m_pc = npc;
        chk("upd_pc", bus_if.pc, m_pc);
        if (npc[1:0] != 2'b00) begin
            chk1("misalign_err", bus_if.fetch_err, 1'b1);
            chk1("misalign_req", bus_if.mem_req_valid, 1'b0);
        end else begin
            chk1("upd_req", bus_if.mem_req_valid, 1'b1);
            chk("upd_addr", bus_if.mem_addr, npc);
        end
    endtask

    task automatic check_dead(input int n);
        for (int i = 0; i < n; i++) begin
            bus_if.mem_req_ready  = 1'b1;
            bus_if.mem_resp_valid = 1'($urandom_range(0, 1));
            bus_if.mem_resp_data  = $urandom();
            bus_if.IDU_ready      = 1'b1;
            bus_if.pc_update      = 1'($urandom_range(0, 1));
            bus_if.dnpc           = $urandom() & 32'hFFFF_FFFC;
            step();
            chk1("dead_req", bus_if.mem_req_valid, 1'b0);
            chk1("dead_valid", bus_if.IFU_valid, 1'b0);
            chk1("dead_err", bus_if.fetch_err, 1'b1);
        end
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        step();
        step();
        rst   = 1'b0;
        m_pc  = RESET_PC;
        m_cnt = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        idle_inputs();
        rst   = 1'b1;
        m_pc  = RESET_PC;
        m_cnt = 32'd0;
        step();
        step();
        check_reset_vals("reset");
        rst = 1'b0;

        // First fetch from RESET_PC, decoder stalls 5 cycles.
        issue_req(0);
        respond(1, 32'h0000_0413, 1'b0);
        hold_and_take(5, 32'h0000_0413);
        exec_update(2, 32'h8000_0010);

        // Best case: request accepted at once, one-cycle response.
        issue_req(0);
        respond(1, 32'h0010_0093, 1'b0);
        hold_and_take(0, 32'h0010_0093);
        exec_update(0, 32'h8000_0100);

        // Response in the last permitted wait cycle.
        issue_req(3);
        respond(TO, 32'hCAFE_0013, 1'b0);
        hold_and_take(1, 32'hCAFE_0013);
        exec_update(1, 32'h8000_0200);

        // Randomised instruction stream.
        for (int it = 0; it < 12; it++) begin
            d = $urandom();
            issue_req(int'($urandom_range(0, 3)));
            respond(int'($urandom_range(1, TO)), d, 1'b0);
            hold_and_take(int'($urandom_range(0, 4)), d);
            exec_update(int'($urandom_range(0, 3)), $urandom() & 32'hFFFF_FFFC);
        end

        // Bus error on the response.
        issue_req(0);
        respond(2, 32'h1234_5678, 1'b1);
        check_dead(6);
        do_reset();

        // Reset while waiting for a response; the late response is ignored.
        issue_req(1);
        step();
        rst = 1'b1;
        #1;
        check_reset_vals("rst_in_wait");
        step();
        rst = 1'b0;
        bus_if.mem_resp_valid = 1'b1;
        bus_if.mem_resp_data  = 32'hBAD0_BAD0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk1("late_resp_valid", bus_if.IFU_valid, 1'b0);
            chk("late_resp_addr", bus_if.mem_addr, RESET_PC);
        end
        bus_if.mem_resp_valid = 1'b0;
        issue_req(0);
        respond(1, 32'h0000_0513, 1'b0);
        hold_and_take(0, 32'h0000_0513);
        exec_update(0, 32'h8000_0002);
        check_dead(6);
        do_reset();

        // Memory never answers: fault after exactly TO wait cycles.
        issue_req(0);
        for (int k = 1; k < TO; k++) begin
            step();
            chk1("timeout_early", bus_if.fetch_err, 1'b0);
        end
        step();
        chk1("timeout_err", bus_if.fetch_err, 1'b1);
        check_dead(4);
        do_reset();
        issue_req(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
